// File: rtl/keypad_if.sv
// keypad_if: row/column pins plus the event FIFO and interrupt signals shared with the APB peripheral
interface keypad_if;
  logic        enable;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [1:0]  row_index;
  logic [15:0] key_state;
  logic        evt_valid;
  logic [4:0]  evt_code;
  logic        evt_pop;
  logic        key_interrupt;
  logic        overflow;
  logic        clr_ovf;
  modport master (
    output enable, col, evt_pop, clr_ovf,
    input  row, row_index, key_state, evt_valid, evt_code, key_interrupt, overflow
  );
  modport slave (
    input  enable, col, evt_pop, clr_ovf,
    output row, row_index, key_state, evt_valid, evt_code, key_interrupt, overflow
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad row scanner with per-key scan debounce and a press/release event FIFO
module keypad_scan_ctrl #(
  parameter int DWELL_CYCLES = 1000,
  parameter int DEB_SCANS    = 3,
  parameter int FIFO_DEPTH   = 4
) (
  input logic     clk,
  input logic     rst,
  keypad_if.slave kp
);
  localparam int DW = $clog2(DWELL_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, UPDATE} state_t;
  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [3:0]    p_q, p_d;
  logic [3:0]    row_q, row_d;
  logic [15:0]   raw_q, key_q;
  logic [2:0]    cnt_q [16];
  logic [4:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   fcnt_q;
  logic          ovf_q;
  logic          diff, fire, full, push, pop;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = '0;
    p_d     = '0;
    case (state_q)
      IDLE: state_d = kp.enable ? SETTLE : IDLE;
      SETTLE: begin
        if (!kp.enable) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (dwell_q == DW'(DWELL_CYCLES - 1)) state_d = SAMPLE;
        else dwell_d = dwell_q + 1'b1;
      end
      SAMPLE: begin
        state_d = !kp.enable ? IDLE : (idx_q == 2'd3) ? UPDATE : SETTLE;
        idx_d   = (kp.enable && idx_q != 2'd3) ? idx_q + 1'b1 : 2'd0;
      end
      UPDATE: begin
        p_d = p_q + 1'b1;
        if (p_q == 4'd15) state_d = kp.enable ? SETTLE : IDLE;
      end
    endcase
    row_d = (state_d == SETTLE || state_d == SAMPLE) ? ~(4'b0001 << idx_d) : 4'hF;
  end
  assign diff = raw_q[p_q] != key_q[p_q];
  assign fire = state_q == UPDATE && diff && cnt_q[p_q] == 3'(DEB_SCANS - 1);
  // fullness is judged before the same-cycle pop, so a pop never makes room for this push
  assign full = fcnt_q == (AW+1)'(FIFO_DEPTH);
  assign push = fire && !full;
  assign pop  = kp.evt_pop && fcnt_q != '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dwell_q <= '0;
      p_q     <= '0;
      row_q   <= 4'hF;
      raw_q   <= '0;
      key_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      fcnt_q  <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < 16; i++) cnt_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      p_q     <= p_d;
      row_q   <= row_d;
      if (state_q == SAMPLE && kp.enable) raw_q[idx_q*4 +: 4] <= ~kp.col;
      if (state_q == UPDATE) begin
        if (!diff) cnt_q[p_q] <= '0;
        else if (fire) begin
          cnt_q[p_q] <= '0;
          key_q[p_q] <= ~key_q[p_q];
        end else cnt_q[p_q] <= cnt_q[p_q] + 3'd1;
      end
      if (push) begin
        mem_q[wp_q] <= {raw_q[p_q], p_q};
        wp_q        <= wp_q + 1'b1;
      end
      if (pop) rp_q <= rp_q + 1'b1;
      fcnt_q <= fcnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      ovf_q  <= (fire && full) || (ovf_q && !kp.clr_ovf);
    end
  end
  assign kp.row           = row_q;
  assign kp.row_index     = idx_q;
  assign kp.key_state     = key_q;
  assign kp.evt_valid     = fcnt_q != '0;
  assign kp.evt_code      = kp.evt_valid ? mem_q[rp_q] : 5'd0;
  assign kp.key_interrupt = kp.evt_valid;
  assign kp.overflow      = ovf_q;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed scenarios plus random key/pop/enable traffic against a scan-time model
module tb_keypad_scan_ctrl;
  localparam int DWC  = 4;
  localparam int DEB  = 3;
  localparam int FD   = 4;
  localparam int ROWT = DWC + 1;
  localparam int UPD0 = 4 * ROWT;
  logic        clk, rst;
  logic [15:0] pressed;
  int          n_chk, n_fail;
  keypad_if kp();
  keypad_scan_ctrl #(.DWELL_CYCLES(DWC), .DEB_SCANS(DEB), .FIFO_DEPTH(FD)) dut (
    .clk(clk),
    .rst(rst),
    .kp (kp)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // keypad matrix: a pressed key pulls its column low while its row is driven low
  always_comb begin
    kp.col = 4'hF;
    for (int r = 0; r < 4; r++) if (!kp.row[r]) kp.col = kp.col & ~pressed[r*4 +: 4];
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // model: position m_t within a scan (rows occupy 0..UPD0-1, update sweep UPD0..UPD0+15)
  bit         m_run;
  int         m_t;
  bit [15:0]  m_raw, m_key;
  int         m_cnt [16];
  bit [4:0]   m_q [$];
  bit         m_ovf;
  always @(posedge clk) begin : model
    bit       fire, full;
    int       p;
    logic [3:0] e_row;
    logic [1:0] e_idx;
    if (rst) begin
      m_run = 0; m_t = 0; m_raw = 0; m_key = 0; m_ovf = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_q.delete();
    end else begin
      fire = 0;
      p    = 0;
      full = m_q.size() == FD;
      if (m_run && m_t >= UPD0) begin
        p = m_t - UPD0;
        if (m_raw[p] == m_key[p]) m_cnt[p] = 0;
        else if (m_cnt[p] == DEB - 1) begin
          m_key[p] = ~m_key[p];
          m_cnt[p] = 0;
          fire = 1;
        end else m_cnt[p]++;
      end
      if (kp.evt_pop && m_q.size() > 0) void'(m_q.pop_front());
      if (fire && !full) m_q.push_back({m_raw[p], 4'(p)});
      m_ovf = (fire && full) || (m_ovf && !kp.clr_ovf);
      if (m_run && m_t < UPD0 && m_t % ROWT == ROWT - 1 && kp.enable)
        m_raw[(m_t/ROWT)*4 +: 4] = pressed[(m_t/ROWT)*4 +: 4];
      if (!m_run) begin
        if (kp.enable) begin m_run = 1; m_t = 0; end
      end else if (m_t < UPD0) begin
        if (!kp.enable) m_run = 0; else m_t++;
      end else if (m_t == UPD0 + 15) begin
        if (kp.enable) m_t = 0; else m_run = 0;
      end else m_t++;
    end
    e_row = (m_run && m_t < UPD0) ? ~(4'b0001 << (m_t / ROWT)) : 4'hF;
    e_idx = (m_run && m_t < UPD0) ? 2'(m_t / ROWT) : 2'd0;
    #1;
    check("row", kp.row, e_row);
    check("row_index", kp.row_index, e_idx);
    check("key_state", kp.key_state, m_key);
    check("evt_valid", kp.evt_valid, m_q.size() > 0);
    check("evt_code", kp.evt_code, m_q.size() > 0 ? m_q[0] : 5'd0);
    check("key_interrupt", kp.key_interrupt, m_q.size() > 0);
    check("overflow", kp.overflow, m_ovf);
  end
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask
  task automatic pop1();
    kp.evt_pop = 1'b1; step(); kp.evt_pop = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 16 && kp.evt_valid; i++) pop1();
    kp.clr_ovf = 1'b1; step(); kp.clr_ovf = 1'b0;
  endtask
  task automatic wait_row(input logic [3:0] r, input string name);
    int n;
    n = 0;
    while (kp.row !== r && n < 100) begin step(); n++; end
    check(name, kp.row, r);
  endtask
  initial begin
    logic [4:0] codes [4];
    int n;
    n_chk = 0; n_fail = 0;
    rst = 1'b1; pressed = '0;
    kp.enable = 1'b0; kp.evt_pop = 1'b0; kp.clr_ovf = 1'b0;
    step(3);
    rst = 1'b0;
    step(100);
    check("idle row", kp.row, 4'hF);
    check("idle key_state", kp.key_state, 16'h0);
    check("idle evt_valid", kp.evt_valid, 1'b0);
    check("idle overflow", kp.overflow, 1'b0);
    kp.enable = 1'b1;
    step();
    check("first row", kp.row, 4'b1110);
    step(5);
    check("second row", kp.row, 4'b1101);
    pressed = 16'h0040;
    n = 0;
    while (!kp.key_state[6] && n < 200) begin step(); n++; end
    check("press6 state", kp.key_state[6], 1'b1);
    check("press6 code", kp.evt_code, 5'b1_0110);
    check("press6 irq", kp.key_interrupt, 1'b1);
    pop1();
    check("press6 popped", kp.evt_valid, 1'b0);
    pressed = 16'h0;
    n = 0;
    while (!kp.evt_valid && n < 200) begin step(); n++; end
    check("release6 code", kp.evt_code, 5'b0_0110);
    check("release6 state", kp.key_state, 16'h0);
    pop1();
    pressed = 16'h0040;
    step(2 * (UPD0 + 16));
    pressed = 16'h0;
    step(150);
    check("bounce state", kp.key_state[6], 1'b0);
    check("bounce no event", kp.evt_valid, 1'b0);
    pressed = 16'h001F;
    n = 0;
    while (!kp.overflow && n < 200) begin step(); n++; end
    check("ovf set", kp.overflow, 1'b1);
    check("ovf key_state", kp.key_state, 16'h001F);
    codes = '{5'b1_0000, 5'b1_0001, 5'b1_0010, 5'b1_0011};
    for (int i = 0; i < 4; i++) begin
      check("ovf fifo order", kp.evt_code, codes[i]);
      pop1();
    end
    check("ovf drained", kp.evt_valid, 1'b0);
    kp.clr_ovf = 1'b1; step(); kp.clr_ovf = 1'b0;
    check("ovf cleared", kp.overflow, 1'b0);
    pressed = 16'h0;
    step(180);
    drain();
    wait_row(4'b1110, "sync row0 k9");
    pressed = 16'h0200;
    wait_row(4'b1011, "reach row2");
    kp.enable = 1'b0;
    step();
    check("abort row", kp.row, 4'hF);
    check("abort row_index", kp.row_index, 2'd0);
    step(10);
    check("abort no event", kp.evt_valid, 1'b0);
    check("abort key_state", kp.key_state, 16'h0);
    kp.enable = 1'b1;
    step();
    check("restart row", kp.row, 4'b1110);
    n = 0;
    while (!kp.evt_valid && n < 200) begin step(); n++; end
    check("k9 latency", n, 102);
    check("k9 code", kp.evt_code, 5'b1_1001);
    pressed = 16'h0;
    step(180);
    drain();
    wait_row(4'b1110, "sync row0 pp");
    pressed = 16'h0027;
    n = 0;
    while (kp.key_state !== 16'h0007 && n < 200) begin step(); n++; end
    check("three queued", kp.key_state, 16'h0007);
    step(2);
    pop1();
    check("pushpop state", kp.key_state, 16'h0027);
    check("pushpop ovf", kp.overflow, 1'b0);
    codes = '{5'b1_0001, 5'b1_0010, 5'b1_0101, 5'b0};
    for (int i = 0; i < 3; i++) begin
      check("pushpop order", kp.evt_code, codes[i]);
      pop1();
    end
    check("pushpop empty", kp.evt_valid, 1'b0);
    pressed = 16'h0;
    step(180);
    drain();
    for (int i = 0; i < 4000; i++) begin
      int k;
      k = $urandom_range(0, 15);
      if ($urandom_range(0, 29) == 0) pressed[k] = ~pressed[k];
      kp.evt_pop = $urandom_range(0, 3) == 0;
      kp.clr_ovf = $urandom_range(0, 63) == 0;
      kp.enable  = $urandom_range(0, 299) != 0;
      rst        = i >= 2000 && i < 2002;
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
